// File: rtl/host_gen_pkg.sv
// host_gen_pkg: shared types and helpers for the charging-datapath stimulus host.
//   state_e      : run FSM states
//   LFSR_TAPS    : 16-bit Fibonacci tap mask (taps 16,14,13,11)
//   SKIP_PERIOD  : every SKIP_PERIOD-th packet is sent uncharged when skipping is on
//   clog2()      : ceil(log2(v)) for sizing counters
//   lfsr_next()  : one LFSR step
package host_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_TRAFFIC,
        ST_READ
    } state_e;

    // Tap positions 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam int          SKIP_PERIOD = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/host_gen_if.sv
// host_gen_if: the three valid/ready ports between the stimulus host and the
// charging engine.
//   w_cnt_* : counter-write request (id + record data)
//   r_cnt_* : counter-read request (id)
//   in_*    : packet input (id, length, target counter, charge enable, uplink)
// master = host side (drives vld/payload), slave = engine side (drives rdy).
interface host_gen_if #(
    parameter int CNT_ID_W   = 14,
    parameter int CNT_DATA_W = 512,
    parameter int PKT_ID_W   = 96,
    parameter int PKT_LEN_W  = 16
);
    logic                  w_cnt_vld;
    logic                  w_cnt_rdy;
    logic [CNT_ID_W-1:0]   w_cnt_id;
    logic [CNT_DATA_W-1:0] w_cnt_data;

    logic                  r_cnt_vld;
    logic                  r_cnt_rdy;
    logic [CNT_ID_W-1:0]   r_cnt_id;

    logic                  in_vld;
    logic                  in_rdy;
    logic [PKT_ID_W-1:0]   in_pkt_id;
    logic [PKT_LEN_W-1:0]  in_pkt_len;
    logic [CNT_ID_W-1:0]   in_cnt_id;
    logic                  in_cnt_en;
    logic                  in_ul;

    modport master (
        output w_cnt_vld, w_cnt_id, w_cnt_data,
        input  w_cnt_rdy,
        output r_cnt_vld, r_cnt_id,
        input  r_cnt_rdy,
        output in_vld, in_pkt_id, in_pkt_len, in_cnt_id, in_cnt_en, in_ul,
        input  in_rdy
    );

    modport slave (
        input  w_cnt_vld, w_cnt_id, w_cnt_data,
        output w_cnt_rdy,
        input  r_cnt_vld, r_cnt_id,
        output r_cnt_rdy,
        input  in_vld, in_pkt_id, in_pkt_len, in_cnt_id, in_cnt_en, in_ul,
        output in_rdy
    );
endinterface

// File: rtl/host_gen_lfsr.sv
// host_gen_lfsr: 16-bit Fibonacci LFSR used for packet lengths.
//   clk_i, rst_i : clock, synchronous active-high reset (reloads SEED)
//   step_i       : advance one step this cycle
//   value_o      : current value
//   next_o       : value after one step (look-ahead for registered payloads)
module host_gen_lfsr
    import host_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        step_i,
    output logic [15:0] value_o,
    output logic [15:0] next_o
);
    logic [15:0] value_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)       value_q <= SEED;
        else if (step_i) value_q <= lfsr_next(value_q);
    end

    assign value_o = value_q;
    assign next_o  = lfsr_next(value_q);
endmodule

// File: rtl/host_gen.sv
// host_gen: parametrised stimulus host for the charging datapath.
//   asclk, areset    : clock, synchronous active-high reset
//   start_w          : rising edge starts a write run (INIT then TRAFFIC)
//   start_r          : rising edge starts a READ run
//   bus (master)     : counter-write, counter-read and packet handshakes
//   busy             : FSM is not IDLE
//   done             : one-cycle pulse after the last accept of a run
// All outputs come straight from registers; next values are computed from the
// accept of the current cycle so back-to-back transfers need no bubble.
module host_gen
    import host_gen_pkg::*;
#(
    parameter int                    CNT_ID_W   = 14,
    parameter int                    CNT_DATA_W = 512,
    parameter int                    PKT_ID_W   = 96,
    parameter int                    PKT_LEN_W  = 16,
    parameter int                    NUM_CNT    = 16384,
    parameter int                    NUM_PKT    = 256,
    parameter logic [CNT_DATA_W-1:0] INIT_DATA  = '0,
    parameter int                    MIN_LEN    = 64,
    parameter int                    LEN_MASK   = 1023,
    parameter logic [15:0]           LFSR_SEED  = 16'hACE1,
    parameter bit                    SKIP_EN    = 1'b1
) (
    input  logic       asclk,
    input  logic       areset,
    input  logic       start_w,
    input  logic       start_r,
    host_gen_if.master bus,
    output logic       busy,
    output logic       done
);
    localparam int MAXN = (NUM_CNT > NUM_PKT) ? NUM_CNT : NUM_PKT;
    localparam int CW   = clog2(MAXN + 1);

    localparam logic [CW-1:0]       LAST_IDX = CW'(NUM_CNT - 1);
    localparam logic [CW-1:0]       LAST_PKT = CW'(NUM_PKT - 1);
    localparam logic [CNT_ID_W-1:0] LAST_ID  = CNT_ID_W'(NUM_CNT - 1);

    function automatic logic [PKT_LEN_W-1:0] len_of(input logic [15:0] l);
        return PKT_LEN_W'(MIN_LEN + int'(l & 16'(LEN_MASK)));
    endfunction

    function automatic logic skip_of(input logic [CW-1:0] nn);
        return SKIP_EN && ((32'(nn) % SKIP_PERIOD) == SKIP_PERIOD - 1);
    endfunction

    state_e state_q, state_d;
    logic   start_w_q, start_r_q;
    logic   [CW-1:0] idx_q, idx_d, n_q, n_d;

    logic                  w_vld_q, w_vld_d;
    logic [CNT_ID_W-1:0]   w_id_q, w_id_d;
    logic [CNT_DATA_W-1:0] w_data_q, w_data_d;
    logic                  r_vld_q, r_vld_d;
    logic [CNT_ID_W-1:0]   r_id_q, r_id_d;
    logic                  in_vld_q, in_vld_d;
    logic [PKT_ID_W-1:0]   pkt_id_q, pkt_id_d;
    logic [PKT_LEN_W-1:0]  pkt_len_q, pkt_len_d;
    logic [CNT_ID_W-1:0]   cnt_id_q, cnt_id_d;
    logic                  cnt_en_q, cnt_en_d;
    logic                  ul_q, ul_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic        lfsr_step;
    logic [15:0] lfsr_val, lfsr_nxt;

    logic start_w_edge, start_r_edge;
    logic w_acc, r_acc, in_acc;
    logic [CW-1:0] idx_inc, n_inc;

    assign start_w_edge = start_w & ~start_w_q;
    assign start_r_edge = start_r & ~start_r_q;
    assign w_acc        = w_vld_q & bus.w_cnt_rdy;
    assign r_acc        = r_vld_q & bus.r_cnt_rdy;
    assign in_acc       = in_vld_q & bus.in_rdy;
    assign idx_inc      = idx_q + 1'b1;
    assign n_inc        = n_q + 1'b1;

    host_gen_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i   (asclk),
        .rst_i   (areset),
        .step_i  (lfsr_step),
        .value_o (lfsr_val),
        .next_o  (lfsr_nxt)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;
        w_vld_d   = w_vld_q;
        w_id_d    = w_id_q;
        w_data_d  = w_data_q;
        r_vld_d   = r_vld_q;
        r_id_d    = r_id_q;
        in_vld_d  = in_vld_q;
        pkt_id_d  = pkt_id_q;
        pkt_len_d = pkt_len_q;
        cnt_id_d  = cnt_id_q;
        cnt_en_d  = cnt_en_q;
        ul_d      = ul_q;
        done_d    = 1'b0;
        lfsr_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // start_w is checked first, so a simultaneous start_r edge is dropped.
                if (start_w_edge) begin
                    state_d  = ST_INIT;
                    idx_d    = '0;
                    w_vld_d  = 1'b1;
                    w_id_d   = '0;
                    w_data_d = INIT_DATA;
                end else if (start_r_edge) begin
                    state_d = ST_READ;
                    idx_d   = '0;
                    r_vld_d = 1'b1;
                    r_id_d  = '0;
                end
            end

            ST_INIT: begin
                if (w_acc) begin
                    if (idx_q == LAST_IDX) begin
                        // Present packet 0 right away: no bubble between phases.
                        state_d   = ST_TRAFFIC;
                        idx_d     = '0;
                        n_d       = '0;
                        w_vld_d   = 1'b0;
                        in_vld_d  = 1'b1;
                        pkt_id_d  = '0;
                        pkt_len_d = len_of(lfsr_val);
                        cnt_id_d  = '0;
                        ul_d      = 1'b0;
                        cnt_en_d  = ~skip_of('0);
                    end else begin
                        idx_d  = idx_inc;
                        w_id_d = CNT_ID_W'(idx_inc);
                    end
                end
            end

            ST_TRAFFIC: begin
                if (in_acc) begin
                    lfsr_step = 1'b1;
                    if (n_q == LAST_PKT) begin
                        state_d  = ST_IDLE;
                        in_vld_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        // Next length uses the post-step LFSR value.
                        n_d       = n_inc;
                        pkt_id_d  = PKT_ID_W'(n_inc);
                        pkt_len_d = len_of(lfsr_nxt);
                        cnt_id_d  = (cnt_id_q == LAST_ID) ? '0 : cnt_id_q + 1'b1;
                        ul_d      = n_inc[0];
                        cnt_en_d  = ~skip_of(n_inc);
                    end
                end
            end

            ST_READ: begin
                if (r_acc) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        r_vld_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_inc;
                        r_id_d = CNT_ID_W'(idx_inc);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge asclk) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            start_w_q <= 1'b0;
            start_r_q <= 1'b0;
            idx_q     <= '0;
            n_q       <= '0;
            w_vld_q   <= 1'b0;
            w_id_q    <= '0;
            w_data_q  <= '0;
            r_vld_q   <= 1'b0;
            r_id_q    <= '0;
            in_vld_q  <= 1'b0;
            pkt_id_q  <= '0;
            pkt_len_q <= '0;
            cnt_id_q  <= '0;
            cnt_en_q  <= 1'b0;
            ul_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_w_q <= start_w;
            start_r_q <= start_r;
            idx_q     <= idx_d;
            n_q       <= n_d;
            w_vld_q   <= w_vld_d;
            w_id_q    <= w_id_d;
            w_data_q  <= w_data_d;
            r_vld_q   <= r_vld_d;
            r_id_q    <= r_id_d;
            in_vld_q  <= in_vld_d;
            pkt_id_q  <= pkt_id_d;
            pkt_len_q <= pkt_len_d;
            cnt_id_q  <= cnt_id_d;
            cnt_en_q  <= cnt_en_d;
            ul_q      <= ul_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.w_cnt_vld  = w_vld_q;
    assign bus.w_cnt_id   = w_id_q;
    assign bus.w_cnt_data = w_data_q;
    assign bus.r_cnt_vld  = r_vld_q;
    assign bus.r_cnt_id   = r_id_q;
    assign bus.in_vld     = in_vld_q;
    assign bus.in_pkt_id  = pkt_id_q;
    assign bus.in_pkt_len = pkt_len_q;
    assign bus.in_cnt_id  = cnt_id_q;
    assign bus.in_cnt_en  = cnt_en_q;
    assign bus.in_ul      = ul_q;
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: tb/tb_host_gen.sv
// tb_host_gen: directed bench for host_gen with NUM_CNT=4, NUM_PKT=8.
module tb_host_gen;
    localparam int          NC    = 4;
    localparam int          NP    = 8;
    localparam logic [511:0] IDATA = 512'h1234_5678;

    logic asclk = 1'b0;
    logic areset = 1'b1;
    logic start_w = 1'b0;
    logic start_r = 1'b0;
    logic busy, done;

    host_gen_if #(.CNT_ID_W(14), .CNT_DATA_W(512), .PKT_ID_W(96), .PKT_LEN_W(16)) bus ();

    host_gen #(
        .CNT_ID_W(14), .CNT_DATA_W(512), .PKT_ID_W(96), .PKT_LEN_W(16),
        .NUM_CNT(NC), .NUM_PKT(NP), .INIT_DATA(IDATA), .MIN_LEN(64),
        .LEN_MASK(1023), .LFSR_SEED(16'hACE1), .SKIP_EN(1'b1)
    ) dut (
        .asclk   (asclk),
        .areset  (areset),
        .start_w (start_w),
        .start_r (start_r),
        .bus     (bus),
        .busy    (busy),
        .done    (done)
    );

    always #5 asclk = ~asclk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] m;   // reference LFSR

    typedef struct {
        int w_vld; int w_id; int in_vld; int pkt_id; int cnt_id;
        int ul; int en; int busy; int done;
    } row_t;
    row_t tbl[14];

    function automatic logic [15:0] mstep(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic int mlen(input logic [15:0] l);
        return 64 + int'(l & 16'd1023);
    endfunction

    task automatic tick();
        @(posedge asclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_busy(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            seen = busy;
        end
        chk({nm, "_busy_rise"}, seen, 1);
    endtask

    task automatic wait_done(input string nm, input int lim);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            tick();
            seen = done;
        end
        chk({nm, "_done"}, seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_done, r_seen, pulsed, found;
        int n_exp, stall, idx_exp, ph;

        // fields: w_vld w_id in_vld pkt_id cnt_id ul en busy done
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[1]  = '{1, 1, 0, 0, 0, 0, 0, 1, 0};
        tbl[2]  = '{1, 2, 0, 0, 0, 0, 0, 1, 0};
        tbl[3]  = '{1, 3, 0, 0, 0, 0, 0, 1, 0};
        tbl[4]  = '{0, 0, 1, 0, 0, 0, 1, 1, 0};
        tbl[5]  = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
        tbl[6]  = '{0, 0, 1, 2, 2, 0, 1, 1, 0};
        tbl[7]  = '{0, 0, 1, 3, 3, 1, 1, 1, 0};
        tbl[8]  = '{0, 0, 1, 4, 0, 0, 1, 1, 0};
        tbl[9]  = '{0, 0, 1, 5, 1, 1, 1, 1, 0};
        tbl[10] = '{0, 0, 1, 6, 2, 0, 1, 1, 0};
        tbl[11] = '{0, 0, 1, 7, 3, 1, 0, 1, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

        bus.w_cnt_rdy = 1'b0;
        bus.r_cnt_rdy = 1'b0;
        bus.in_rdy    = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_w_vld",  bus.w_cnt_vld, 0);
        chk("rst_r_vld",  bus.r_cnt_vld, 0);
        chk("rst_in_vld", bus.in_vld, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_done",   done, 0);
        chk("rst_en",     bus.in_cnt_en, 0);
        chk("rst_ul",     bus.in_ul, 0);
        chk("rst_len",    bus.in_pkt_len, 0);
        chk("rst_data",   (bus.w_cnt_data == '0), 1);
        areset = 1'b0;
        tick();
        m = 16'hACE1;

        // Full write run, all ready high, compared against the table
        bus.w_cnt_rdy = 1'b1;
        bus.in_rdy    = 1'b1;
        start_w = 1'b1;
        wait_busy("run1");
        start_w = 1'b0;
        for (int r = 0; r < 14; r++) begin
            if (r > 0) tick();
            chk($sformatf("run1_w_vld[%0d]", r),  bus.w_cnt_vld, tbl[r].w_vld);
            chk($sformatf("run1_in_vld[%0d]", r), bus.in_vld, tbl[r].in_vld);
            chk($sformatf("run1_r_vld[%0d]", r),  bus.r_cnt_vld, 0);
            chk($sformatf("run1_busy[%0d]", r),   busy, tbl[r].busy);
            chk($sformatf("run1_done[%0d]", r),   done, tbl[r].done);
            if (tbl[r].w_vld != 0) begin
                chk($sformatf("run1_w_id[%0d]", r), bus.w_cnt_id, tbl[r].w_id);
                chk($sformatf("run1_w_data[%0d]", r), (bus.w_cnt_data == IDATA), 1);
            end
            if (tbl[r].in_vld != 0) begin
                chk($sformatf("run1_pkt_id[%0d]", r), bus.in_pkt_id, tbl[r].pkt_id);
                chk($sformatf("run1_cnt_id[%0d]", r), bus.in_cnt_id, tbl[r].cnt_id);
                chk($sformatf("run1_ul[%0d]", r),     bus.in_ul, tbl[r].ul);
                chk($sformatf("run1_en[%0d]", r),     bus.in_cnt_en, tbl[r].en);
                if (r == 4) chk("run1_first_len", bus.in_pkt_len, 289);
                chk($sformatf("run1_len[%0d]", r), bus.in_pkt_len, mlen(m));
                chk($sformatf("run1_len_rng[%0d]", r),
                    (bus.in_pkt_len >= 16'd64 && bus.in_pkt_len <= 16'd1087), 1);
                m = mstep(m);
            end
        end

        // Backpressure: in_rdy low for 3 cycles while packet 2 is offered
        start_w = 1'b1;
        wait_busy("bp");
        start_w = 1'b0;
        n_exp = 0; stall = 0; got_done = 1'b0;
        for (int c = 0; c < 60 && !got_done; c++) begin
            if (done) begin
                got_done = 1'b1;
                chk("bp_busy_at_done", busy, 0);
            end else begin
                if (bus.in_vld) begin
                    chk($sformatf("bp_pkt_id[%0d]", c), bus.in_pkt_id, n_exp);
                    chk($sformatf("bp_cnt_id[%0d]", c), bus.in_cnt_id, n_exp % NC);
                    chk($sformatf("bp_ul[%0d]", c),     bus.in_ul, n_exp & 1);
                    chk($sformatf("bp_en[%0d]", c),     bus.in_cnt_en, (n_exp % 8 == 7) ? 0 : 1);
                    chk($sformatf("bp_len[%0d]", c),    bus.in_pkt_len, mlen(m));
                    if (n_exp == 2 && stall < 3) begin
                        bus.in_rdy = 1'b0;
                        stall++;
                    end else begin
                        bus.in_rdy = 1'b1;
                        n_exp++;
                        m = mstep(m);
                    end
                end
                tick();
            end
        end
        chk("bp_done_seen", got_done, 1);
        chk("bp_pkt_count", n_exp, NP);
        chk("bp_stalls", stall, 3);
        tick();
        chk("bp_done_pulse", done, 0);

        // Read run with r_cnt_rdy toggling 1,0,1,0
        start_r = 1'b1;
        wait_busy("rd");
        start_r = 1'b0;
        idx_exp = 0; ph = 0; got_done = 1'b0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            if (done) begin
                got_done = 1'b1;
                chk("rd_busy_at_done", busy, 0);
            end else begin
                if (bus.r_cnt_vld) begin
                    chk($sformatf("rd_id[%0d]", c), bus.r_cnt_id, idx_exp);
                    chk($sformatf("rd_no_w[%0d]", c), bus.w_cnt_vld | bus.in_vld, 0);
                    bus.r_cnt_rdy = (ph == 0);
                    if (ph == 0) idx_exp++;
                    ph ^= 1;
                end
                tick();
            end
        end
        chk("rd_done_seen", got_done, 1);
        chk("rd_count", idx_exp, NC);
        bus.r_cnt_rdy = 1'b1;
        tick();
        chk("rd_done_pulse", done, 0);

        // Simultaneous starts: write wins; start_r during TRAFFIC is ignored
        start_w = 1'b1;
        start_r = 1'b1;
        wait_busy("arb");
        chk("arb_w_vld", bus.w_cnt_vld, 1);
        chk("arb_r_vld", bus.r_cnt_vld, 0);
        start_w = 1'b0;
        start_r = 1'b0;
        r_seen = 1'b0; pulsed = 1'b0; got_done = 1'b0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            tick();
            r_seen |= bus.r_cnt_vld;
            got_done = done;
            if (bus.in_vld && !pulsed) begin
                start_r = 1'b1;
                pulsed = 1'b1;
            end
        end
        chk("arb_done_seen", got_done, 1);
        for (int c = 0; c < 4; c++) begin
            tick();
            r_seen |= bus.r_cnt_vld;
            chk($sformatf("arb_idle_busy[%0d]", c), busy, 0);
        end
        chk("arb_no_read", r_seen, 0);
        start_r = 1'b0;

        // Reset mid-TRAFFIC with start_w held high
        start_w = 1'b1;
        wait_busy("rst");
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            tick();
            found = bus.in_vld && (bus.in_pkt_id == 96'd5);
        end
        chk("rst_reach_pkt5", found, 1);
        areset = 1'b1;
        tick();
        chk("mid_rst_w_vld",  bus.w_cnt_vld, 0);
        chk("mid_rst_r_vld",  bus.r_cnt_vld, 0);
        chk("mid_rst_in_vld", bus.in_vld, 0);
        chk("mid_rst_busy",   busy, 0);
        chk("mid_rst_done",   done, 0);
        chk("mid_rst_len",    bus.in_pkt_len, 0);
        chk("mid_rst_en",     bus.in_cnt_en, 0);
        areset = 1'b0;
        m = 16'hACE1;
        wait_busy("restart");
        chk("restart_w_vld", bus.w_cnt_vld, 1);
        chk("restart_w_id",  bus.w_cnt_id, 0);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            found = bus.in_vld;
        end
        chk("restart_traffic", found, 1);
        chk("restart_pkt_id", bus.in_pkt_id, 0);
        chk("restart_len", bus.in_pkt_len, 289);
        wait_done("restart", 30);
        start_w = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
